// File: rtl/post_sequencer_if.sv
// Bundles the POST input and the sequencer's control/status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; every signal is a level, with no handshake.
`timescale 1ns/1ps
interface post_sequencer_if;
    logic       post_bit;
    logic       glitch;
    logic       cpu_reset_req_n;
    logic       cpu_slow;
    logic       success;
    logic [7:0] attempts;

    // The sequencer samples post_bit and drives everything else.
    modport master (
        input  post_bit,
        output glitch,
        output cpu_reset_req_n,
        output cpu_slow,
        output success,
        output attempts
    );

    // The CPU/board side drives post_bit and observes the results.
    modport slave (
        output post_bit,
        input  glitch,
        input  cpu_reset_req_n,
        input  cpu_slow,
        input  success,
        input  attempts
    );
endinterface

// File: rtl/post_sequencer.sv
// Counts CPU POST-bit edges, requests a glitch at the target edge, then either latches success or resets the CPU and retries.
// Latency: a pin change is counted 3 cycles later; glitch rises the cycle after the target count. All outputs are registered.
// Backpressure: none. Optional macro POST_SEQ_SLOW_EN enables the cpu_slow (PLL bypass) request.
`timescale 1ns/1ps
module post_sequencer #(
    parameter int unsigned GLITCH_EDGE   = 10,
    parameter int unsigned GLITCH_HOLD   = 20000,
    parameter int unsigned CHECK_TIMEOUT = 480000,
    parameter int unsigned RESET_LEN     = 9600,
    parameter int unsigned SLOW_EDGE     = 8
) (
    input  logic               clk_96m,
    input  logic               rst_n,
    post_sequencer_if.master   seq_if
);

    localparam int unsigned TIMER_W = 20;

    localparam logic [7:0]         EDGE_TGT     = 8'(GLITCH_EDGE);
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(GLITCH_HOLD - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(CHECK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(RESET_LEN - 1);

    // Elaboration-time guards: the timer is 20 bits wide and the edge counter is 8 bits wide.
    if (GLITCH_EDGE < 1 || GLITCH_EDGE > 255) begin : g_bad_edge
        $error("post_sequencer: GLITCH_EDGE must be 1..255");
    end
    if (GLITCH_HOLD < 1 || GLITCH_HOLD > (1 << TIMER_W)) begin : g_bad_hold
        $error("post_sequencer: GLITCH_HOLD must be 1..2^20");
    end
    if (CHECK_TIMEOUT < 1 || CHECK_TIMEOUT > (1 << TIMER_W)) begin : g_bad_timeout
        $error("post_sequencer: CHECK_TIMEOUT must be 1..2^20");
    end
    if (RESET_LEN < 1 || RESET_LEN > (1 << TIMER_W)) begin : g_bad_reset
        $error("post_sequencer: RESET_LEN must be 1..2^20");
    end
    if (SLOW_EDGE >= GLITCH_EDGE) begin : g_bad_slow
        $error("post_sequencer: SLOW_EDGE must be below GLITCH_EDGE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_RESET,
        S_PASS
    } state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [7:0]         edge_cnt;
    logic [7:0]         attempts_q;
    logic               glitch_q;
    logic               reset_req_n_q;
    logic               success_q;

    logic sync1;
    logic sync2;
    logic post_dly;
    logic post_edge;

    // Two-flop synchronizer plus one delay flop; any level change of post_bit is an edge.
    always_ff @(posedge clk_96m or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            post_dly <= 1'b0;
        end else begin
            sync1    <= seq_if.post_bit;
            sync2    <= sync1;
            post_dly <= sync2;
        end
    end

    assign post_edge = sync2 ^ post_dly;

    // Attempt sequencer: count edges, hold glitch, watch for boot progress, reset the CPU on failure.
    always_ff @(posedge clk_96m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            edge_cnt      <= '0;
            attempts_q    <= '0;
            glitch_q      <= 1'b0;
            reset_req_n_q <= 1'b1;
            success_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Target count reached on the previous edge: arm this cycle.
                    if (edge_cnt == EDGE_TGT) begin
                        state    <= S_ARMED;
                        glitch_q <= 1'b1;
                        timer    <= '0;
                    end else if (post_edge && edge_cnt != 8'hFF) begin
                        edge_cnt <= edge_cnt + 8'd1;
                    end
                end
                S_ARMED: begin
                    // Edges are ignored while the glitcher is working.
                    if (timer == HOLD_LAST) begin
                        state    <= S_CHECK;
                        glitch_q <= 1'b0;
                        timer    <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CHECK: begin
                    // An edge wins over a simultaneous timeout.
                    if (post_edge) begin
                        state     <= S_PASS;
                        success_q <= 1'b1;
                    end else if (timer == TIMEOUT_LAST) begin
                        state         <= S_RESET;
                        timer         <= '0;
                        reset_req_n_q <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESET: begin
                    if (timer == RESET_LAST) begin
                        state         <= S_IDLE;
                        reset_req_n_q <= 1'b1;
                        edge_cnt      <= '0;
                        timer         <= '0;
                        if (attempts_q != 8'hFF) begin
                            attempts_q <= attempts_q + 8'd1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_PASS: begin
                    // Terminal until rst_n.
                    success_q     <= 1'b1;
                    glitch_q      <= 1'b0;
                    reset_req_n_q <= 1'b1;
                end
                default: begin
                    state         <= S_IDLE;
                    glitch_q      <= 1'b0;
                    reset_req_n_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef POST_SEQ_SLOW_EN
    localparam logic [7:0] SLOW_TGT = 8'(SLOW_EDGE);

    logic slow_q;

    // Slow request: set once the IDLE count reaches SLOW_EDGE, held through ARMED, dropped on CHECK entry.
    always_ff @(posedge clk_96m or negedge rst_n) begin
        if (!rst_n) begin
            slow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (edge_cnt == SLOW_TGT) slow_q <= 1'b1;
                S_ARMED: if (timer == HOLD_LAST) slow_q <= 1'b0;
                default: slow_q <= 1'b0;
            endcase
        end
    end

    assign seq_if.cpu_slow = slow_q;
`else
    assign seq_if.cpu_slow = 1'b0;
`endif

    assign seq_if.glitch          = glitch_q;
    assign seq_if.cpu_reset_req_n = reset_req_n_q;
    assign seq_if.success         = success_q;
    assign seq_if.attempts        = attempts_q;

endmodule

// File: doc/post_sequencer.md
Name: post_sequencer

Overview:
- Glitch-attempt controller that sits directly upstream of the reset glitcher.
- Watches one CPU POST bit and counts its edges. At the target POST edge it raises the glitch request consumed by the glitcher, then checks whether boot progresses.
- On failure it requests a CPU reset and starts a new attempt. On success it latches a pass indication.
- Runs single-edge on the 96 MHz board clock.

Parameters:
- GLITCH_EDGE, 10, POST-bit edge count (rising + falling) at which the glitch request is asserted; range 1..255.
- GLITCH_HOLD, 20000, cycles the glitch request stays high. Must exceed the glitcher's start delay plus pulse length, expressed in clk_96m cycles.
- CHECK_TIMEOUT, 480000, cycles to wait for the next POST edge after the glitch request drops (5 ms).
- RESET_LEN, 9600, cycles cpu_reset_req_n is held low on failure (100 us).
- SLOW_EDGE, 8, edge count at which cpu_slow asserts; optional feature only; must be < GLITCH_EDGE.

Ports:
- clk_96m  in  1  96 MHz board clock, rising edge only.
- rst_n  in  1  asynchronous active-low reset.
- post_bit  in  1  asynchronous POST bit from the CPU.
- glitch  out  1  glitch request to the glitcher; high = glitcher counting and firing.
- cpu_reset_req_n  out  1  active-low CPU reset request; high when idle.
- cpu_slow  out  1  PLL-bypass/slow request; constant 0 when the optional feature is compiled out.
- success  out  1  high once boot progress is seen after a glitch.
- attempts  out  8  number of failed attempts, saturating.

Behaviour:
Reset values:
- glitch=0, cpu_reset_req_n=1, cpu_slow=0, success=0, attempts=0.
- edge_cnt=0, timer=0, state=IDLE.
- Assertion of rst_n takes effect immediately (asynchronous), including mid-glitch or mid-reset.

Input path:
- post_bit passes through a 2-flop synchronizer and one delay flop.
- edge = sync2 XOR delay. An edge becomes visible 3 cycles after the pin changes.

edge_cnt:
- 8 bits; increments on edge only in IDLE; saturates at 255.
- Cleared on entry to IDLE from RESET.

States:
- IDLE
  - Count edges.
  - When an edge makes edge_cnt == GLITCH_EDGE: next cycle go to ARMED, glitch=1, timer=0.
- ARMED
  - glitch=1; timer increments; edges ignored.
  - When timer == GLITCH_HOLD-1: go to CHECK, glitch=0, timer=0.
  - Total glitch-high time is exactly GLITCH_HOLD cycles.
- CHECK
  - glitch=0; timer increments.
  - On an edge: go to PASS.
  - At timer == CHECK_TIMEOUT-1 with no edge: go to RESET, timer=0, cpu_reset_req_n=0.
  - An edge arriving in the same cycle as timeout expiry wins, so the block goes to PASS.
- RESET
  - cpu_reset_req_n=0 for exactly RESET_LEN cycles.
  - On exit: attempts++ (saturating at 255, no wrap), edge_cnt=0, cpu_reset_req_n=1, go to IDLE.
- PASS
  - success=1, glitch=0, cpu_reset_req_n=1.
  - Terminal; left only via rst_n.

Timer:
- 20 bits, unsigned. Sized so the largest default (480000) fits.
- Parameters exceeding 2^20 are illegal; a simulation-only check errors on them.

Output timing and encoding:
- All outputs are registered; no combinational path from post_bit to any output.
- glitch never toggles more than once per attempt.
- glitch and cpu_reset_req_n=0 are never asserted in the same cycle.

Optional Feature:
- Macro: POST_SEQ_SLOW_EN.
- Defined:
  - cpu_slow rises the cycle after an IDLE edge makes edge_cnt == SLOW_EDGE.
  - It stays high through ARMED and falls on entry to CHECK.
  - It is forced 0 in RESET and PASS.
- Undefined:
  - cpu_slow is tied 0.
  - No SLOW_EDGE comparison logic is synthesized.
  - All other timing is identical.

Test Plan:
1. Parameters GLITCH_EDGE=4, GLITCH_HOLD=10, CHECK_TIMEOUT=50, RESET_LEN=5; toggle post_bit 4 times, 20 cycles apart -> glitch rises 4 cycles after the 4th pin toggle and is high exactly 10 cycles; no 5th edge -> cpu_reset_req_n low exactly 5 cycles, starting 50 cycles after glitch falls; then attempts=1, edge_cnt=0.
2. Same setup; toggle post_bit once, 20 cycles after glitch falls -> success=1; cpu_reset_req_n stays 1; further toggles cause no change.
3. Time a toggle so the synchronized edge lands exactly on the timeout-expiry cycle (timer == 49) -> PASS, with no reset pulse.
4. Run 260 consecutive failed attempts -> attempts holds at 255, with no wrap to 0.
5. Assert rst_n low mid-ARMED (timer=5) and mid-RESET -> glitch=0 and cpu_reset_req_n=1 in the same cycle; all counters 0; the next attempt counts from edge 0.
6. With POST_SEQ_SLOW_EN and SLOW_EDGE=2 -> cpu_slow rises after edge 2, stays high through ARMED, falls on CHECK entry. Without the macro -> cpu_slow stays 0 throughout the same run.
